parking_gate_arbiter: RTL and testbench

Shares one barrier gate between an entry lane and an exit lane of the car park. It validates entry requests against the password check and the lot capacity, and round-robins the lanes when both request. It holds the gate open or shows a deny indication for a fixed number of cycles, and tracks lot occupancy. It sits above the per-lane password logic and drives the gate actuator and the green/red LEDs.

---
 rtl/parking_pkg.sv | 20 ++
 rtl/parking_gate_arbiter_if.sv | 25 ++
 rtl/parking_hold_timer.sv | 24 ++
 rtl/parking_gate_arbiter.sv | 135 +++++++++++++
 tb/tb_parking_gate_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types for the parking gate arbiter: controller state and lane identity.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        DENY     = 2'd3
    } gate_state_t;

    typedef enum logic {
        ENTRY = 1'b0,
        EXIT  = 1'b1
    } lane_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Lane requests in, gate/LED/grant/occupancy status out, bundled for the arbiter.
interface parking_gate_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             entry_req;
    logic             pass_ok;
    logic             exit_req;
    logic             gate_open;
    logic             green_led;
    logic             red_led;
    logic             grant_entry;
    logic             grant_exit;
    logic [CNT_W-1:0] occupancy;
    logic             lot_full;

    modport master (
        output entry_req, pass_ok, exit_req,
        input  gate_open, green_led, red_led, grant_entry, grant_exit, occupancy, lot_full
    );

    modport slave (
        input  entry_req, pass_ok, exit_req,
        output gate_open, green_led, red_led, grant_entry, grant_exit, occupancy, lot_full
    );
endinterface

// File: rtl/parking_hold_timer.sv
// Loadable down-counter shared by the open and deny holds; expired while the count is zero.
module parking_hold_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);
endmodule

// File: rtl/parking_gate_arbiter.sv
// One barrier shared by the entry and exit lanes: round-robin arbitration,
// password/capacity validation, timed open/deny holds and occupancy tracking.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY    = 8,
    parameter int OPEN_CYCLES = 4,
    parameter int DENY_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    parking_gate_arbiter_if.slave  bus
);
    localparam int CNT_W    = $clog2(CAPACITY + 1);
    localparam int HOLD_MAX = max_int(OPEN_CYCLES, DENY_CYCLES);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    // The timer is loaded with N-1 so the hold state lasts exactly N cycles.
    localparam logic [HOLD_W-1:0] OPEN_LOAD = HOLD_W'(OPEN_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DENY_LOAD = HOLD_W'(DENY_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CAP_VAL   = CNT_W'(CAPACITY);

    gate_state_t      r_state;
    lane_t            r_last_served;
    logic             r_entry_armed;
    logic             r_exit_armed;
    logic [CNT_W-1:0] r_occupancy;
    logic             r_gate_open;
    logic             r_green_led;
    logic             r_red_led;
    logic             r_grant_entry;
    logic             r_grant_exit;

    logic              w_lot_full;
    logic              w_entry_cand;
    logic              w_exit_cand;
    logic              w_serve_entry;
    logic              w_serve_exit;
    logic              w_entry_ok;
    logic              w_timer_load;
    logic [HOLD_W-1:0] w_timer_val;
    logic              w_expired;

    always_comb begin
        w_lot_full    = (r_occupancy == CAP_VAL);
        w_entry_cand  = bus.entry_req & r_entry_armed;
        w_exit_cand   = bus.exit_req & r_exit_armed & (r_occupancy != '0);
        // On a tie, the lane not served last time wins.
        w_serve_entry = w_entry_cand & (!w_exit_cand | (r_last_served == EXIT));
        w_serve_exit  = w_exit_cand & (!w_entry_cand | (r_last_served == ENTRY));
        w_entry_ok    = bus.pass_ok & !w_lot_full;
        w_timer_load  = (r_state == IDLE) & (w_serve_entry | w_serve_exit);
        w_timer_val   = (w_serve_entry & !w_entry_ok) ? DENY_LOAD : OPEN_LOAD;
    end

    parking_hold_timer #(
        .WIDTH (HOLD_W)
    ) u_hold_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_served <= EXIT;
            r_entry_armed <= 1'b1;
            r_exit_armed  <= 1'b1;
            r_occupancy   <= '0;
            r_gate_open   <= 1'b0;
            r_green_led   <= 1'b0;
            r_red_led     <= 1'b0;
            r_grant_entry <= 1'b0;
            r_grant_exit  <= 1'b0;
        end else begin
            r_grant_entry <= 1'b0;
            r_grant_exit  <= 1'b0;
            // A low request re-arms its lane in any state; grants need req high so never collide.
            if (!bus.entry_req) r_entry_armed <= 1'b1;
            if (!bus.exit_req)  r_exit_armed  <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_serve_entry) begin
                        r_last_served <= ENTRY;
                        if (w_entry_ok) begin
                            r_state       <= OPEN_IN;
                            r_occupancy   <= r_occupancy + CNT_W'(1);
                            r_grant_entry <= 1'b1;
                            r_gate_open   <= 1'b1;
                            r_green_led   <= 1'b1;
                            r_entry_armed <= 1'b0;
                        end else begin
                            r_state   <= DENY;
                            r_red_led <= 1'b1;
                        end
                    end else if (w_serve_exit) begin
                        r_last_served <= EXIT;
                        r_state       <= OPEN_OUT;
                        r_occupancy   <= r_occupancy - CNT_W'(1);
                        r_grant_exit  <= 1'b1;
                        r_gate_open   <= 1'b1;
                        r_green_led   <= 1'b1;
                        r_exit_armed  <= 1'b0;
                    end
                end
                OPEN_IN, OPEN_OUT: begin
                    if (w_expired) begin
                        r_state     <= IDLE;
                        r_gate_open <= 1'b0;
                        r_green_led <= 1'b0;
                    end
                end
                DENY: begin
                    if (w_expired) begin
                        r_state   <= IDLE;
                        r_red_led <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gate_open   = r_gate_open;
    assign bus.green_led   = r_green_led;
    assign bus.red_led     = r_red_led;
    assign bus.grant_entry = r_grant_entry;
    assign bus.grant_exit  = r_grant_exit;
    assign bus.occupancy   = r_occupancy;
    assign bus.lot_full    = w_lot_full;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed-vector bench for parking_gate_arbiter with CAPACITY=2, OPEN=4, DENY=2.
module tb_parking_gate_arbiter;
    localparam int CAPACITY    = 2;
    localparam int OPEN_CYCLES = 4;
    localparam int DENY_CYCLES = 2;
    localparam int CNT_W       = $clog2(CAPACITY + 1);

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    parking_gate_arbiter_if #(.CNT_W(CNT_W)) bus ();

    parking_gate_arbiter #(
        .CAPACITY    (CAPACITY),
        .OPEN_CYCLES (OPEN_CYCLES),
        .DENY_CYCLES (DENY_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.pass_ok   = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({bus.gate_open, bus.green_led, bus.red_led, bus.grant_entry, bus.grant_exit, bus.lot_full} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bus.gate_open, bus.green_led, bus.red_led, bus.grant_entry, bus.grant_exit, bus.lot_full});
        end
        n_vec++;
        if (bus.occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy);
        end
        $display("test_reset done");
    endtask

    task automatic test_entry_grant();
        int gcnt;
        int extra;
        do_reset();
        bus.entry_req = 1'b1;
        bus.pass_ok   = 1'b1;
        tick();
        n_vec++;
        if (bus.grant_entry !== 1'b1 || bus.occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL entry_grant: grant=%b occ=%0d expected grant=1 occ=1", bus.grant_entry, bus.occupancy);
        end
        gcnt = 0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.gate_open === 1'b1 && bus.green_led === 1'b1) gcnt++;
            if (i > 0 && (bus.grant_entry === 1'b1 || bus.gate_open === 1'b1 && i >= OPEN_CYCLES)) extra++;
            tick();
        end
        n_vec++;
        if (gcnt !== OPEN_CYCLES) begin
            n_err++;
            $display("FAIL open_length: got %0d cycles expected %0d", gcnt, OPEN_CYCLES);
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL held_req_regrant: got %0d extra events expected 0", extra);
        end
        bus.entry_req = 1'b0;
        tick();
        bus.entry_req = 1'b1;
        tick();
        n_vec++;
        if (bus.grant_entry !== 1'b1 || bus.occupancy !== 2'd2 || bus.lot_full !== 1'b1) begin
            n_err++;
            $display("FAIL rearm_grant: grant=%b occ=%0d full=%b expected 1/2/1",
                     bus.grant_entry, bus.occupancy, bus.lot_full);
        end
        $display("test_entry_grant done");
    endtask

    task automatic test_bad_password();
        int rcnt;
        int gbad;
        do_reset();
        bus.entry_req = 1'b1;
        bus.pass_ok   = 1'b0;
        tick();
        bus.pass_ok = 1'b1;
        rcnt = 0;
        gbad = 0;
        for (int i = 0; i < DENY_CYCLES; i++) begin
            if (bus.red_led === 1'b1) rcnt++;
            if (bus.gate_open !== 1'b0 || bus.grant_entry !== 1'b0 || bus.occupancy !== 2'd0) gbad++;
            tick();
        end
        n_vec++;
        if (rcnt !== DENY_CYCLES || gbad !== 0) begin
            n_err++;
            $display("FAIL deny_hold: red_cycles=%0d bad=%0d expected %0d/0", rcnt, gbad, DENY_CYCLES);
        end
        n_vec++;
        if (bus.red_led !== 1'b0 || bus.grant_entry !== 1'b0) begin
            n_err++;
            $display("FAIL deny_release: red=%b grant=%b expected 0/0", bus.red_led, bus.grant_entry);
        end
        tick();
        n_vec++;
        if (bus.grant_entry !== 1'b1 || bus.occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL retry_grant: grant=%b occ=%0d expected 1/1", bus.grant_entry, bus.occupancy);
        end
        $display("test_bad_password done");
    endtask

    task automatic test_lot_full();
        do_reset();
        bus.pass_ok   = 1'b1;
        bus.entry_req = 1'b1;
        tick();
        bus.entry_req = 1'b0;
        ticks(OPEN_CYCLES);
        bus.entry_req = 1'b1;
        tick();
        bus.entry_req = 1'b0;
        ticks(OPEN_CYCLES);
        n_vec++;
        if (bus.occupancy !== 2'd2 || bus.lot_full !== 1'b1 || bus.gate_open !== 1'b0) begin
            n_err++;
            $display("FAIL fill_lot: occ=%0d full=%b gate=%b expected 2/1/0", bus.occupancy, bus.lot_full, bus.gate_open);
        end
        bus.entry_req = 1'b1;
        tick();
        n_vec++;
        if (bus.red_led !== 1'b1 || bus.grant_entry !== 1'b0 || bus.gate_open !== 1'b0) begin
            n_err++;
            $display("FAIL full_deny: red=%b grant=%b gate=%b expected 1/0/0", bus.red_led, bus.grant_entry, bus.gate_open);
        end
        bus.entry_req = 1'b0;
        tick();
        n_vec++;
        if (bus.red_led !== 1'b1) begin
            n_err++;
            $display("FAIL full_deny_len2: red=%b expected 1", bus.red_led);
        end
        tick();
        n_vec++;
        if (bus.red_led !== 1'b0 || bus.occupancy !== 2'd2) begin
            n_err++;
            $display("FAIL full_deny_end: red=%b occ=%0d expected 0/2", bus.red_led, bus.occupancy);
        end
        bus.exit_req = 1'b1;
        tick();
        n_vec++;
        if (bus.grant_exit !== 1'b1 || bus.occupancy !== 2'd1 || bus.lot_full !== 1'b0) begin
            n_err++;
            $display("FAIL exit_from_full: grant=%b occ=%0d full=%b expected 1/1/0",
                     bus.grant_exit, bus.occupancy, bus.lot_full);
        end
        bus.exit_req = 1'b0;
        $display("test_lot_full done");
    endtask

    task automatic test_exit_empty();
        int bad;
        do_reset();
        bus.exit_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.grant_exit !== 1'b0 || bus.gate_open !== 1'b0 || bus.red_led !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL exit_at_empty: got %0d bad cycles expected 0", bad);
        end
        bus.exit_req  = 1'b0;
        bus.pass_ok   = 1'b1;
        bus.entry_req = 1'b1;
        tick();
        bus.entry_req = 1'b0;
        ticks(OPEN_CYCLES);
        bus.exit_req = 1'b1;
        tick();
        n_vec++;
        if (bus.grant_exit !== 1'b1 || bus.occupancy !== 2'd0 || bus.gate_open !== 1'b1) begin
            n_err++;
            $display("FAIL exit_grant: grant=%b occ=%0d gate=%b expected 1/0/1",
                     bus.grant_exit, bus.occupancy, bus.gate_open);
        end
        bus.exit_req = 1'b0;
        $display("test_exit_empty done");
    endtask

    task automatic test_round_robin();
        int g_cyc[3];
        logic g_lane[3];
        int ng;
        int both;
        do_reset();
        bus.pass_ok   = 1'b1;
        bus.entry_req = 1'b1;
        tick();
        bus.entry_req = 1'b0;
        ticks(OPEN_CYCLES);
        bus.entry_req = 1'b1;
        tick();
        bus.entry_req = 1'b0;
        ticks(OPEN_CYCLES);
        bus.exit_req = 1'b1;
        tick();
        bus.exit_req = 1'b0;
        ticks(OPEN_CYCLES);
        n_vec++;
        if (bus.occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL rr_setup_occ: got %0d expected 1", bus.occupancy);
        end
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        ng = 0;
        both = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (bus.grant_entry === 1'b1 && bus.grant_exit === 1'b1) both++;
            if (bus.grant_entry === 1'b1 || bus.grant_exit === 1'b1) begin
                if (ng < 3) begin
                    g_cyc[ng]  = c;
                    g_lane[ng] = bus.grant_exit;
                end
                ng++;
            end
            bus.entry_req = !bus.grant_entry;
            bus.exit_req  = !bus.grant_exit;
        end
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        n_vec++;
        if (ng !== 3 || both !== 0) begin
            n_err++;
            $display("FAIL rr_count: grants=%0d both=%0d expected 3/0", ng, both);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (g_cyc[k] !== 5 * k || g_lane[k] !== logic'(k % 2)) begin
                    n_err++;
                    $display("FAIL rr_grant%0d: cycle=%0d lane=%0d expected cycle=%0d lane=%0d",
                             k, g_cyc[k], g_lane[k], 5 * k, k % 2);
                end
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.pass_ok   = 1'b1;
        bus.entry_req = 1'b1;
        tick();
        ticks(2);
        n_vec++;
        if (bus.gate_open !== 1'b1 || bus.occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL pre_reset_open: gate=%b occ=%0d expected 1/1", bus.gate_open, bus.occupancy);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (bus.gate_open !== 1'b0 || bus.green_led !== 1'b0 || bus.occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL async_reset: gate=%b green=%b occ=%0d expected 0/0/0",
                     bus.gate_open, bus.green_led, bus.occupancy);
        end
        bus.entry_req = 1'b0;
        tick();
        reset = 1'b0;
        $display("test_async_reset done");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.pass_ok   = 1'b0;
        test_reset();
        test_entry_grant();
        test_bad_password();
        test_lot_full();
        test_exit_empty();
        test_round_robin();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
